// File: rtl/decodificador_cuadratura.sv
// ============================================================================
// decodificador_cuadratura: synchronised, debounced quadrature decoder that
// emits one enable strobe per legal encoder step.   Revision 1.0
// ============================================================================
`default_nettype none

module decodificador_cuadratura #(
  parameter int DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic qa,
  input  logic qb,
  input  logic enable_in,
  input  logic clear_err,
  output logic up_down,
  output logic enable,
  output logic err
);

  localparam logic [7:0] DEB_LIMIT = 8'(DEB_CYCLES);

  // Channel vectors use bit 1 for A and bit 0 for B throughout.
  logic [1:0]       sync1_q;
  logic [1:0]       sync2_q;
  logic [1:0]       filt_q;
  logic [1:0]       filt_d;
  logic [1:0][7:0]  cnt_q;
  logic [1:0][7:0]  cnt_d;
  logic [1:0]       prev_q;
  logic             enable_q;
  logic             enable_d;
  logic             up_down_q;
  logic             up_down_d;
  logic             err_q;
  logic             err_d;

  logic [1:0]       change;
  logic             step_legal;
  logic             step_illegal;
  logic             step_dir;

  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] != filt_q[i]) begin
        // The edge that would make the count reach DEB_CYCLES accepts the level.
        if (cnt_q[i] == DEB_LIMIT - 8'd1) begin
          filt_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 8'd1;
        end
      end
    end
  end

  always_comb begin
    change       = filt_q ^ prev_q;
    step_legal   = ^change;
    step_illegal = &change;
    // For a single-bit Gray step, old A xor new B is 1 exactly on forward moves.
    step_dir     = prev_q[1] ^ filt_q[0];

    enable_d  = enable_in & step_legal;
    up_down_d = up_down_q;
    if (enable_in && step_legal) begin
      up_down_d = step_dir;
    end
    err_d = (enable_in & step_illegal) | (err_q & ~clear_err);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      filt_q    <= '0;
      cnt_q     <= '0;
      prev_q    <= '0;
      enable_q  <= 1'b0;
      up_down_q <= 1'b1;
      err_q     <= 1'b0;
    end else begin
      sync1_q   <= {qa, qb};
      sync2_q   <= sync1_q;
      filt_q    <= filt_d;
      cnt_q     <= cnt_d;
      prev_q    <= filt_q;
      enable_q  <= enable_d;
      up_down_q <= up_down_d;
      err_q     <= err_d;
    end
  end

  assign up_down = up_down_q;
  assign enable  = enable_q;
  assign err     = err_q;

endmodule

`default_nettype wire

// File: tb/tb_decodificador_cuadratura.sv
// ============================================================================
// tb_decodificador_cuadratura: scoreboard bench with a history-window model.
// Revision 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_decodificador_cuadratura;

  localparam int DEB = 4;

  logic clk = 1'b0;
  logic rst;
  logic qa;
  logic qb;
  logic enable_in;
  logic clear_err;
  logic up_down;
  logic enable;
  logic err;

  decodificador_cuadratura #(.DEB_CYCLES(DEB)) dut (
    .clk       (clk),
    .rst       (rst),
    .qa        (qa),
    .qb        (qb),
    .enable_in (enable_in),
    .clear_err (clear_err),
    .up_down   (up_down),
    .enable    (enable),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    bit dir;
  } exp_t;

  exp_t sb_q[$];
  exp_t e;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int pulses = 0;
  int last_pulse_cyc = 0;
  int cap_cyc = 0;
  int p0;

  // Reference model state: accepted levels, the levels one edge earlier,
  // and the raw input samples (index 0 = most recent edge).
  bit fa = 0, fb = 0, fa_old = 0, fb_old = 0;
  bit hist_a[0:255];
  bit hist_b[0:255];
  bit err_m = 0;
  bit ud_m = 1;

  function automatic int pos(bit a, bit b);
    case ({a, b})
      2'b00:   return 0;
      2'b01:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  task automatic check(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp_v);
    end
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      fa = 0; fb = 0; fa_old = 0; fb_old = 0;
      for (int j = 0; j < 256; j++) begin
        hist_a[j] = 0;
        hist_b[j] = 0;
      end
      err_m = 0;
      ud_m  = 1;
      sb_q.delete();
    end else begin
      int d;
      bit flip_a;
      bit flip_b;
      cyc++;
      // Step distance along the Gray cycle 00,01,11,10 seen one edge ago.
      d = (pos(fa, fb) - pos(fa_old, fb_old) + 4) % 4;
      if (enable_in && d == 1) begin
        sb_q.push_back('{cyc, 1'b1});
        ud_m = 1;
      end else if (enable_in && d == 3) begin
        sb_q.push_back('{cyc, 1'b0});
        ud_m = 0;
      end
      if (enable_in && d == 2) err_m = 1;
      else if (clear_err)      err_m = 0;
      fa_old = fa;
      fb_old = fb;
      // A level is accepted once the last DEB synchronised samples all differ.
      flip_a = 1;
      flip_b = 1;
      for (int j = 1; j <= DEB; j++) begin
        if (hist_a[j] == fa) flip_a = 0;
        if (hist_b[j] == fb) flip_b = 0;
      end
      if (flip_a) fa = !fa;
      if (flip_b) fb = !fb;
      for (int j = DEB; j >= 1; j--) begin
        hist_a[j] = hist_a[j-1];
        hist_b[j] = hist_b[j-1];
      end
      hist_a[0] = qa;
      hist_b[0] = qb;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      if (enable) begin
        pulses++;
        last_pulse_cyc = cyc;
        if (sb_q.size() == 0) begin
          check("unexpected_pulse", 1, 0);
        end else begin
          e = sb_q.pop_front();
          check("pulse_cycle", cyc, e.cyc);
          check("pulse_dir", int'(up_down), int'(e.dir));
        end
      end else if (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
        e = sb_q.pop_front();
        check("missing_pulse", 0, 1);
      end
      check("err", int'(err), int'(err_m));
      check("up_down", int'(up_down), int'(ud_m));
    end
  end

  task automatic hold(input bit a, input bit b, input int n);
    if (qa != a || qb != b) cap_cyc = cyc + 1;
    qa = a;
    qb = b;
    repeat (n) @(negedge clk);
  endtask

  task automatic step_chk(input bit a, input bit b, input string name);
    hold(a, b, 10);
    check(name, last_pulse_cyc - cap_cyc, DEB + 2);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_enable"}, int'(enable), 0);
    check({tag, "_up_down"}, int'(up_down), 1);
    check({tag, "_err"}, int'(err), 0);
  endtask

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    qa = 1'b0;
    qb = 1'b0;
    enable_in = 1'b1;
    clear_err = 1'b0;
    repeat (3) @(negedge clk);
    #1 check_reset_outputs("reset");
    @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    hold(0, 0, 10);

    // Forward steps
    p0 = pulses;
    step_chk(0, 1, "fwd_lat_01");
    step_chk(1, 1, "fwd_lat_11");
    step_chk(1, 0, "fwd_lat_10");
    step_chk(0, 0, "fwd_lat_00");
    check("fwd_pulses", pulses - p0, 4);
    check("fwd_up_down", int'(up_down), 1);

    // Reverse steps
    p0 = pulses;
    step_chk(1, 0, "rev_lat_10");
    step_chk(1, 1, "rev_lat_11");
    step_chk(0, 1, "rev_lat_01");
    step_chk(0, 0, "rev_lat_00");
    check("rev_pulses", pulses - p0, 4);
    hold(0, 0, 10);
    check("rev_up_down_held", int'(up_down), 0);

    // Glitches: 3 cycles is rejected, 4 cycles is accepted (and returns)
    p0 = pulses;
    hold(1, 0, 3);
    hold(0, 0, 12);
    check("glitch3_pulses", pulses - p0, 0);
    p0 = pulses;
    hold(1, 0, 4);
    hold(0, 0, 12);
    check("glitch4_pulses", pulses - p0, 2);

    // Illegal double-bit change, clear, then clear colliding with a new error
    p0 = pulses;
    hold(1, 1, 12);
    check("illegal_pulses", pulses - p0, 0);
    check("illegal_err", int'(err), 1);
    hold(1, 1, 5);
    check("illegal_err_held", int'(err), 1);
    clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;
    check("clear_err", int'(err), 0);
    hold(0, 1, 12);
    qa = 1'b1;
    qb = 1'b0;
    repeat (DEB + 2) @(negedge clk);
    clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;
    check("set_beats_clear", int'(err), 1);
    hold(1, 0, 10);
    clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;
    hold(0, 0, 12);

    // Disabled steps produce nothing, and nothing catches up on re-enable
    enable_in = 1'b0;
    p0 = pulses;
    hold(0, 1, 12);
    hold(1, 1, 12);
    enable_in = 1'b1;
    hold(1, 1, 12);
    check("disabled_pulses", pulses - p0, 0);
    check("disabled_err", int'(err), 0);
    hold(1, 0, 12);
    hold(0, 0, 12);

    // Reset mid-debounce with err=1 and up_down=0 beforehand
    hold(1, 1, 12);
    hold(0, 1, 12);
    check("pre_reset_err", int'(err), 1);
    check("pre_reset_up_down", int'(up_down), 0);
    p0 = pulses;
    qa = 1'b1;
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1 check_reset_outputs("async_reset");
    qa = 1'b0;
    qb = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    hold(0, 0, 15);
    check("post_reset_pulses", pulses - p0, 0);

    // Randomised traffic against the model
    for (int i = 0; i < 60; i++) begin
      enable_in = ($urandom_range(0, 7) != 0);
      clear_err = ($urandom_range(0, 7) == 0);
      hold(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(1, 14));
    end
    enable_in = 1'b1;
    clear_err = 1'b0;
    hold(qa, qb, 20);

    check("scoreboard_drained", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/decodificador_cuadratura.md
DECODIFICADOR_CUADRATURA -- requirements
Module: decodificador_cuadratura

Purpose: quadrature-encoder front end that drives an up/down counter through its up_down/enable step interface (one enable strobe per legal encoder step).

Interface
REQ-001 Parameter DEB_CYCLES, default 4: consecutive stable cycles needed to accept a new input level; legal range 1..255.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset; asynchronous, active-low.
REQ-004 qa  input  1  encoder channel A; asynchronous to clk.
REQ-005 qb  input  1  encoder channel B; asynchronous to clk.
REQ-006 enable_in  input  1  block enable; 0 suppresses strobes and error detection.
REQ-007 clear_err  input  1  synchronous clear of err.
REQ-008 up_down  output  1  direction of the most recent step: 1 = forward/up, 0 = reverse/down.
REQ-009 enable  output  1  one-cycle step strobe for the counter.
REQ-010 err  output  1  sticky illegal-transition flag.

Function
REQ-011 Each of qa and qb SHALL pass through a 2-flop synchronizer (sync1, sync2) before any other use.
REQ-012 Each channel SHALL have an independent debouncer: an 8-bit counter plus a filtered level (a_f, b_f).
REQ-013 The debouncer counter SHALL increment on every edge where sync2 != filtered level, and SHALL clear to 0 on any edge where they are equal.
REQ-014 The filtered level SHALL take the sync2 value on the edge where sync2 has differed for DEB_CYCLES consecutive edges; the counter SHALL clear on that same edge.
REQ-015 A glitch shorter than DEB_CYCLES cycles at sync2 SHALL leave the filtered level unchanged.
REQ-016 The decoder SHALL register prev = {a_f, b_f} every cycle and compare it with the current {a_f, b_f}.
REQ-017 Forward sequence: 00->01->11->10->00. Each forward transition SHALL drive enable=1 for exactly one cycle, with up_down=1 in that same cycle.
REQ-018 Reverse sequence: 00->10->11->01->00. Each reverse transition SHALL drive enable=1 for exactly one cycle, with up_down=0 in that same cycle.
REQ-019 up_down SHALL hold its last value between strobes.
REQ-020 Both filtered bits changing in the same cycle (00<->11, 01<->10) SHALL produce no strobe, SHALL leave up_down unchanged, and SHALL set err=1.
REQ-021 err SHALL remain 1 until clear_err=1 is sampled.
REQ-022 If clear_err is asserted in the same cycle as a new illegal transition, set SHALL take priority and err SHALL stay 1.
REQ-023 When enable_in=0, synchronizers, debouncers and prev SHALL keep tracking; enable SHALL stay 0 and err SHALL not be set.
REQ-024 Re-asserting enable_in SHALL NOT produce a strobe for transitions that occurred while it was 0.
REQ-025 Latency: a qa/qb level first captured by sync1 at edge k SHALL produce its enable strobe registered at edge k+2+DEB_CYCLES.
REQ-026 No more than one strobe SHALL be issued per cycle; enable SHALL never be high in two consecutive cycles unless two legal transitions occur on consecutive edges.

Reset
REQ-027 On rst=0, asynchronously and regardless of clk: all synchronizer flops, a_f, b_f and prev=0; debounce counters=0; enable=0; up_down=1; err=0.
REQ-028 Reset asserted mid-debounce or mid-strobe SHALL abort the operation with no strobe issued.
REQ-029 After reset release, qa=qb=1 held steady SHALL be accepted as 00->11, so err=1 after DEB_CYCLES+2 edges if enable_in=1; the bench accounts for this by starting with qa=qb=0.

Verification (DEB_CYCLES=4)
REQ-030 Forward: starting from 00, drive qa/qb through 01,11,10,00, holding each level 10 cycles -> exactly 4 enable pulses, each 1 cycle wide, up_down=1, each pulse 6 edges after sync1 capture.
REQ-031 Reverse: drive 10,11,01,00 -> 4 pulses with up_down=0; up_down stays 0 afterwards.
REQ-032 Glitch: qa high for 3 cycles, then low -> a_f unchanged, no pulse. qa high for 4 cycles -> a_f=1 and one pulse.
REQ-033 Illegal: drive 00->11 simultaneously -> no pulse, err=1 and held. clear_err for 1 cycle -> err=0. clear_err asserted together with a new 01->10 transition -> err=1.
REQ-034 enable_in=0 during two forward steps, then back to 1 -> no pulses, err=0, no catch-up pulse after re-enable.
REQ-035 Assert rst for 1 cycle, 3 cycles after a qa edge -> outputs at reset values immediately, no pulse after release.
